// File: rtl/dpd_cfg_pkg.sv
// Shared definitions for the DPD LUT configuration sequencer: FSM encoding and default geometry.
package dpd_cfg_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_ID_MAX     = 64;
  localparam int DEF_LUT_ID_W   = 6;
  localparam int DEF_TIMEOUT    = 15;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/dpd_lut_cfg_ctrl_if.sv
// Host command/data handshake plus LUT configuration port, bundled for the sequencer.
interface dpd_lut_cfg_ctrl_if
  import dpd_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ID_MAX     = DEF_ID_MAX,
  parameter int LUT_ID_W   = DEF_LUT_ID_W
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [LUT_ID_W-1:0]   cmd_lut;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  enc;
  logic [ID_MAX-1:0]     lutIdc;
  logic                  wec;
  logic [ADDR_WIDTH-1:0] addrc;
  logic [DATA_WIDTH-1:0] dinc;
  logic [DATA_WIDTH-1:0] doutc;
  logic                  validc;

  // master is the host plus the LUT it configures; slave is the sequencer
  modport master (
    output cmd_valid, cmd_write, cmd_lut, cmd_addr, cmd_len, wr_data, wr_valid,
           rd_ready, doutc, validc,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err,
           enc, lutIdc, wec, addrc, dinc
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_lut, cmd_addr, cmd_len, wr_data, wr_valid,
           rd_ready, doutc, validc,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, err,
           enc, lutIdc, wec, addrc, dinc
  );

endinterface

// File: rtl/dpd_cfg_timeout.sv
// Loadable down-counter; expired is high once the count has reached zero.
module dpd_cfg_timeout #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/dpd_lut_cfg_ctrl.sv
// Burst sequencer for the DPD actuator LUT configuration port.
// state       | meaning
// IDLE        | ready for a command
// WR          | taking write beats; wr_ready low marks the final strobe cycle
// RD_ISSUE    | read strobe on the LUT port
// RD_WAIT     | waiting for validc, bounded by the timeout counter
// RD_HOLD     | presenting rd_data until the host takes it
module dpd_lut_cfg_ctrl
  import dpd_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ID_MAX     = DEF_ID_MAX,
  parameter int LUT_ID_W   = DEF_LUT_ID_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  dpd_lut_cfg_ctrl_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ID_MAX-1:0] SEL_ONE = {{(ID_MAX-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [LUT_ID_W-1:0]   lut_q, lut_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic                  cmd_ready_q, cmd_ready_d, wr_ready_q, wr_ready_d;
  logic                  rd_valid_q, rd_valid_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d, enc_q, enc_d, wec_q, wec_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, dinc_q, dinc_d;
  logic [ADDR_WIDTH-1:0] addrc_q, addrc_d;
  logic [ID_MAX-1:0]     lut_idc_q, lut_idc_d;
  logic                  tmo_load, tmo_expired;

  dpd_cfg_timeout #(.CNT_W(TMO_W)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load),
    .load_val (TMO_W'(TIMEOUT - 1)),
    .expired  (tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    lut_d      = lut_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wr_ready_d = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    enc_d      = 1'b0;
    wec_d      = 1'b0;
    addrc_d    = '0;
    dinc_d     = '0;
    tmo_load   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          if (int'(bus.cmd_lut) >= ID_MAX) begin
            err_d = 1'b1;
          end else begin
            lut_d  = bus.cmd_lut;
            addr_d = bus.cmd_addr;
            cnt_d  = bus.cmd_len;
            if (bus.cmd_write) begin
              state_d    = ST_WR;
              wr_ready_d = 1'b1;
            end else begin
              state_d = ST_RD_ISSUE;
              enc_d   = 1'b1;
              addrc_d = bus.cmd_addr;
            end
          end
        end
      end
      ST_WR: begin
        if (!wr_ready_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wr_ready_d = 1'b1;
          if (bus.wr_valid) begin
            enc_d   = 1'b1;
            wec_d   = 1'b1;
            addrc_d = addr_q;
            dinc_d  = bus.wr_data;
            if (cnt_q == '0) begin
              wr_ready_d = 1'b0;
            end else begin
              cnt_d  = cnt_q - ADDR_WIDTH'(1);
              addr_d = addr_q + ADDR_WIDTH'(1);
            end
          end
        end
      end
      ST_RD_ISSUE: begin
        state_d  = ST_RD_WAIT;
        tmo_load = 1'b1;
      end
      ST_RD_WAIT: begin
        // a validc arriving in the last allowed cycle still wins over expiry
        if (bus.validc) begin
          rd_data_d  = bus.doutc;
          rd_valid_d = 1'b1;
          state_d    = ST_RD_HOLD;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - ADDR_WIDTH'(1);
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ST_RD_ISSUE;
            enc_d   = 1'b1;
            addrc_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // the done/err cycle still counts as busy; a rejected command never was
    busy_d      = (state_d != ST_IDLE) || done_d || (err_d && (state_q != ST_IDLE));
    lut_idc_d   = busy_d ? (SEL_ONE << lut_d) : '0;
    cmd_ready_d = (state_d == ST_IDLE) && !done_d && !err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lut_q       <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      enc_q       <= 1'b0;
      wec_q       <= 1'b0;
      addrc_q     <= '0;
      dinc_q      <= '0;
      lut_idc_q   <= '0;
    end else begin
      state_q     <= state_d;
      lut_q       <= lut_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      enc_q       <= enc_d;
      wec_q       <= wec_d;
      addrc_q     <= addrc_d;
      dinc_q      <= dinc_d;
      lut_idc_q   <= lut_idc_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.enc       = enc_q;
  assign bus.wec       = wec_q;
  assign bus.addrc     = addrc_q;
  assign bus.dinc      = dinc_q;
  assign bus.lutIdc    = lut_idc_q;

endmodule

// File: tb/tb_dpd_lut_cfg_ctrl.sv
// Directed bench for dpd_lut_cfg_ctrl: host driver in the main thread, LUT model and port monitor on negedge.
module tb_dpd_lut_cfg_ctrl;

  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dpd_lut_cfg_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ID_MAX(64), .LUT_ID_W(7)) bus ();

  dpd_lut_cfg_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .ID_MAX(64), .LUT_ID_W(7), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // LUT model and monitor
  typedef struct packed {
    logic        wec;
    logic [3:0]  addr;
    logic [31:0] din;
    logic [63:0] idc;
  } strobe_t;

  logic [31:0] lut_mem [64][16];
  strobe_t     sq[$];
  int          sc[$];
  int          done_cyc[$];
  int          err_cyc[$];
  int          rv_rise[$];
  int          cyc = 0;
  int          viol = 0;
  int          rdv_cnt = 0;
  int          mon_id;
  bit          no_resp = 1'b0;
  int          lat = 2;
  bit          pv[8];
  logic [31:0] pd[8];
  logic        prv_v = 1'b0;
  logic        prv_r = 1'b0;
  logic [31:0] prv_d = '0;

  function automatic int onehot_idx(input logic [63:0] v);
    int r = 0;
    for (int i = 0; i < 64; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[7] = 1'b0;
    if (bus.enc) begin
      mon_id = onehot_idx(bus.lutIdc);
      sq.push_back({bus.wec, bus.addrc, bus.dinc, bus.lutIdc});
      sc.push_back(cyc);
      if (bus.wec) lut_mem[mon_id][bus.addrc] = bus.dinc;
      else if (!no_resp) begin
        pv[lat] = 1'b1;
        pd[lat] = lut_mem[mon_id][bus.addrc];
      end
    end else if (bus.wec || bus.addrc != '0 || bus.dinc != '0) begin
      viol++;
    end
    bus.validc = pv[0];
    bus.doutc  = pv[0] ? pd[0] : 32'hDEADBEEF;
    if (bus.done) done_cyc.push_back(cyc);
    if (bus.err) err_cyc.push_back(cyc);
    if (bus.done && bus.err) viol++;
    if ($countones(bus.lutIdc) > 1) viol++;
    if (bus.rd_valid) rdv_cnt++;
    if (bus.rd_valid && !prv_v) rv_rise.push_back(cyc);
    if (prv_v && !prv_r && (!bus.rd_valid || bus.rd_data != prv_d)) viol++;
    prv_v = bus.rd_valid;
    prv_r = bus.rd_ready;
    prv_d = bus.rd_data;
  end

  // host side
  logic [31:0] wq[$];
  logic [31:0] rq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    sq.delete(); sc.delete(); done_cyc.delete(); err_cyc.delete();
    rv_rise.delete(); rq.delete(); rdv_cnt = 0;
  endtask

  task automatic send_cmd(input bit wr, input int lut, input int addr, input int len);
    int n = 0;
    bus.cmd_write = wr;
    bus.cmd_lut   = 7'(lut);
    bus.cmd_addr  = 4'(addr);
    bus.cmd_len   = 4'(len);
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drive_writes(input int n);
    int   k = 0;
    int   g = 0;
    logic acc;
    bus.wr_valid = 1'b1;
    bus.wr_data  = wq[0];
    while (k < n && g < 200) begin
      acc = bus.wr_ready;
      tick();
      g++;
      if (acc) begin
        k++;
        bus.wr_data = (k < n) ? wq[k] : 32'h0;
      end
    end
    bus.wr_valid = 1'b0;
    chk("wr_beats", k, n);
  endtask

  task automatic collect_reads(input int n, input bit toggle);
    int k = 0;
    int g = 0;
    while (k < n && g < 400) begin
      if (toggle) bus.rd_ready = g[0];
      if (bus.rd_valid && bus.rd_ready) begin
        rq.push_back(bus.rd_data);
        k++;
      end
      tick();
      g++;
    end
    chk("rd_words", k, n);
  endtask

  task automatic wait_pulse(input bit want_err);
    int g = 0;
    while (!(want_err ? bus.err : bus.done) && g < 60) begin
      tick();
      g++;
    end
    chk(want_err ? "err_seen" : "done_seen", want_err ? bus.err : bus.done, 1);
  endtask

  int wa[4] = '{14, 15, 0, 1};
  int last_s;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_lut = '0;
    bus.cmd_addr = '0; bus.cmd_len = '0; bus.wr_data = '0;
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
    for (int a = 0; a < 16; a++) lut_mem[5][a] = 32'h5A5A0000 + a;

    // reset state
    repeat (3) tick();
    chk("rst_ctl", {bus.busy, bus.done, bus.err, bus.enc, bus.wec, bus.cmd_ready,
                    bus.wr_ready, bus.rd_valid}, 0);
    chk("rst_data", {bus.rd_data, bus.dinc}, 0);
    chk("rst_idc", bus.lutIdc | 64'(bus.addrc), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.cmd_ready, 1);

    // write burst lut 0, 16 words
    clear_logs();
    send_cmd(1'b1, 0, 0, 15);
    chk("wr_busy", bus.busy, 1);
    chk("wr_idc_early", bus.lutIdc, 64'h1);
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(32'h11111111 * i);
    drive_writes(16);
    wait_pulse(1'b0);
    tick();
    chk("wr_after", {bus.busy, bus.cmd_ready, bus.done}, 3'b010);
    chk("wr_after_idc", bus.lutIdc, 0);
    chk("wr_nstrobe", sq.size(), 16);
    for (int i = 0; i < sq.size() && i < 16; i++) begin
      chk("wr_strobe", {sq[i].wec, sq[i].addr, sq[i].din}, {1'b1, 4'(i), 32'h11111111 * i});
      chk("wr_strobe_idc", sq[i].idc, 64'h1);
    end
    last_s = (sc.size() > 0) ? sc[sc.size()-1] : -100;
    chk("wr_contig", last_s - ((sc.size() > 0) ? sc[0] : 0), 15);
    chk("wr_ndone", done_cyc.size(), 1);
    chk("wr_done_lat", ((done_cyc.size() > 0) ? done_cyc[0] : -50) - last_s, 1);

    // read burst lut 0 back, validc latency 2
    clear_logs();
    lat = 2;
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 0, 0, 15);
    collect_reads(16, 1'b0);
    wait_pulse(1'b0);
    tick();
    chk("rd_nstrobe", sq.size(), 16);
    for (int i = 0; i < rq.size() && i < 16; i++)
      chk("rd_data", rq[i], 32'h11111111 * i);
    for (int i = 0; i < sq.size() && i < 16; i++)
      chk("rd_strobe", {sq[i].wec, sq[i].addr}, {1'b0, 4'(i)});
    chk("rd_latency", ((rv_rise.size() > 0) ? rv_rise[0] : 0) - ((sc.size() > 0) ? sc[0] : 0), 3);
    chk("rd_ndone_err", {32'(done_cyc.size()), 32'(err_cyc.size())}, {32'd1, 32'd0});

    // wrap plus backpressure, lut 5
    clear_logs();
    send_cmd(1'b0, 5, 14, 3);
    collect_reads(4, 1'b1);
    bus.rd_ready = 1'b1;
    wait_pulse(1'b0);
    tick();
    chk("wrap_nstrobe", sq.size(), 4);
    for (int i = 0; i < sq.size() && i < 4; i++) begin
      chk("wrap_addr", {sq[i].wec, sq[i].addr}, {1'b0, 4'(wa[i])});
      chk("wrap_idc", sq[i].idc, 64'h20);
    end
    for (int i = 0; i < rq.size() && i < 4; i++)
      chk("wrap_data", rq[i], 32'h5A5A0000 + wa[i]);

    // read timeout
    clear_logs();
    no_resp = 1'b1;
    send_cmd(1'b0, 3, 2, 1);
    wait_pulse(1'b1);
    tick();
    chk("tmo_ready_next", bus.cmd_ready, 1);
    chk("tmo_nstrobe", sq.size(), 1);
    chk("tmo_err_lat", ((err_cyc.size() > 0) ? err_cyc[0] : 0) - ((sc.size() > 0) ? sc[0] : 0), TMO + 1);
    chk("tmo_no_rdv_done", {32'(rdv_cnt), 32'(done_cyc.size())}, 0);
    no_resp = 1'b0;
    repeat (4) tick();

    // reject out-of-range lut, then a normal write
    clear_logs();
    send_cmd(1'b1, 64, 0, 0);
    chk("rej_err", {bus.err, bus.busy, bus.enc}, 3'b100);
    chk("rej_idc", bus.lutIdc, 0);
    tick();
    chk("rej_pulse_end", {bus.err, bus.cmd_ready}, 2'b01);
    chk("rej_nstrobe", sq.size(), 0);
    send_cmd(1'b1, 2, 3, 1);
    wq.delete();
    wq.push_back(32'hCAFE0003);
    wq.push_back(32'hCAFE0004);
    drive_writes(2);
    wait_pulse(1'b0);
    tick();
    chk("rej_wr_nstrobe", sq.size(), 2);
    for (int i = 0; i < sq.size() && i < 2; i++) begin
      chk("rej_wr_strobe", {sq[i].wec, sq[i].addr, sq[i].din}, {1'b1, 4'(3 + i), 32'hCAFE0003 + i});
      chk("rej_wr_idc", sq[i].idc, 64'h4);
    end
    chk("rej_counts", {32'(done_cyc.size()), 32'(err_cyc.size())}, {32'd1, 32'd1});

    // reset during third write word
    clear_logs();
    send_cmd(1'b1, 1, 0, 7);
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(32'h0B0B0000 + i);
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_data = wq[i];
      tick();
    end
    chk("mid_strobe", {bus.enc, bus.addrc}, {1'b1, 4'd2});
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {bus.busy, bus.done, bus.err, bus.enc, bus.wec, bus.cmd_ready,
                        bus.wr_ready, bus.rd_valid}, 0);
    chk("mid_rst_bus", bus.lutIdc | 64'(bus.addrc) | 64'(bus.dinc), 0);
    bus.wr_valid = 1'b0;
    repeat (3) tick();
    chk("mid_no_pulse", {32'(done_cyc.size()), 32'(err_cyc.size())}, 0);
    chk("mid_nstrobe", sq.size(), 2);
    rst = 1'b0;
    tick();
    clear_logs();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 1, 0, 1);
    collect_reads(2, 1'b0);
    wait_pulse(1'b0);
    tick();
    for (int i = 0; i < rq.size() && i < 2; i++)
      chk("mid_readback", rq[i], 32'h0B0B0000 + i);
    chk("mid_read_counts", {32'(done_cyc.size()), 32'(err_cyc.size())}, {32'd1, 32'd0});

    chk("port_invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
